// File: rtl/line_fifo.sv
// line_fifo: single-clock line/frame buffer FIFO, registered read port.
// Params: DATA_WIDTH, ADDR_WIDTH (DEPTH=2**ADDR_WIDTH), AF_LEVEL, AE_LEVEL.
// Ports: clk, reset (async, active-high), en (global enable),
//   push/data_in (write), pop/data_out/data_valid (1-cycle read),
//   full, empty, almost_full, almost_empty, level (0..DEPTH).
// Option: define LINE_FIFO_ERR_FLAG_EN to add sticky overflow/underflow.
module line_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH-4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level
`ifdef LINE_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_TH =
    (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_TH =
    (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  push_acc;
  logic                  pop_acc;

  assign waddr = wptr[ADDR_WIDTH-1:0];
  assign raddr = rptr[ADDR_WIDTH-1:0];

  // Extra wrap bit tells full from empty when addresses match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (waddr == raddr);

  // A pop frees the slot a push needs, so full+pop+push is legal.
  // No bypass: pop against an empty FIFO is never accepted.
  assign pop_acc  = en & pop & ~empty;
  assign push_acc = en & push & (~full | pop_acc);

  assign almost_full  = (level >= AF_TH);
  assign almost_empty = (level <= AE_TH);

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[waddr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_acc;
      if (push_acc)
        wptr <= wptr + 1'b1;
      if (pop_acc) begin
        rptr     <= rptr + 1'b1;
        data_out <= mem[raddr];
      end
      unique case (1'b1)
        push_acc && !pop_acc: level <= level + 1'b1;
        pop_acc && !push_acc: level <= level - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LINE_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (en && push && full && !pop_acc)
        overflow <= 1'b1;
      if (en && pop && empty)
        underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/line_fifo.md
LINE_FIFO -- requirements
Module: line_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, pixel/word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, giving DEPTH = 2**ADDR_WIDTH entries (65536 = one 256x256 frame).
REQ-003 The block SHALL have parameter AF_LEVEL, default 2**ADDR_WIDTH-4, the almost_full threshold.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, the almost_empty threshold.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  global enable; 0 freezes all state.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 data_valid  output  1  data_out updated by a pop this cycle.
REQ-013 full / empty  output  1 each  occupancy status.
REQ-014 almost_full / almost_empty  output  1 each  threshold status.
REQ-015 level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-016 Write/read pointers SHALL be ADDR_WIDTH+1 bits; the MSB is the wrap bit; the lower ADDR_WIDTH bits address memory.
REQ-017 empty SHALL be 1 when pointers are equal; full SHALL be 1 when the MSBs differ and the lower bits are equal; both SHALL be combinational from registered pointers.
REQ-018 Push SHALL be accepted iff en & push & (!full | pop_acc); pop_acc SHALL be en & pop & !empty.
REQ-019 A simultaneous push and pop while full SHALL be accepted together; level SHALL stay DEPTH.
REQ-020 A simultaneous push and pop while empty SHALL accept only the push; there SHALL be no bypass; data_valid SHALL stay 0.
REQ-021 An accepted push SHALL write data_in at wptr and increment wptr modulo 2**(ADDR_WIDTH+1).
REQ-022 An accepted pop SHALL load data_out from mem[rptr] at the same edge, increment rptr, and set data_valid=1 for that cycle only (read latency 1 cycle).
REQ-023 data_out SHALL hold its last value when no pop is accepted.
REQ-024 A rejected push or pop SHALL leave pointers, memory and level unchanged.
REQ-025 level SHALL be registered: +1 on push-only, -1 on pop-only, unchanged on both or neither.
REQ-026 almost_full SHALL be level >= AF_LEVEL; almost_empty SHALL be level <= AE_LEVEL.
REQ-027 With en=0, all registers SHALL hold their values and data_valid SHALL be 0.

Reset
REQ-028 Asserting reset SHALL immediately clear wptr, rptr, level, data_out and data_valid to 0, and the error flags when present; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 A reset asserted mid-operation SHALL discard all stored entries; the first accepted push after reset release SHALL write address 0.

Configuration
REQ-031 With macro LINE_FIFO_ERR_FLAG_EN defined, the block SHALL add outputs overflow and underflow (1 bit each).
REQ-032 overflow SHALL set sticky on en & push & full & !pop_acc; underflow SHALL set sticky on en & pop & empty; both SHALL clear only on reset.
REQ-033 Without LINE_FIFO_ERR_FLAG_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2, DATA_WIDTH=8)
REQ-034 Reset, then push 0x10..0x17 -> full=1 and level=8 after the 8th edge; almost_full=1 from level 6; a 9th push is ignored; overflow=1 if the macro is enabled.
REQ-035 From full, pop 8 times -> data_out is 0x10..0x17 in order, each with a 1-cycle data_valid; then empty=1 and level=0.
REQ-036 At level 8, push 0xAA with pop -> data_out=0x10, level stays 8, and 0xAA is read last after 7 more pops.
REQ-037 At level 0, push 0x55 with pop -> data_valid=0, level=1; the next pop gives data_out=0x55.
REQ-038 Perform 20 push/pop pairs across pointer wrap with en toggled low on alternate cycles -> no data loss, and no state change during en=0 cycles.
REQ-039 Assert reset at level 5 -> level=0 and empty=1 immediately; a subsequent push/pop returns the new data, not stale data.
